// File: rtl/embcpu8k_onchip_mem_burst_adapter.sv
// Avalon-MM burst slave in front of a single-port on-chip RAM: one word per cycle, wrapping address.
// Optional macro EMBCPU8K_MEM_RDATA_REG_EN adds an output register stage on the read data path.
module embcpu8k_onchip_mem_burst_adapter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     avs_address,
  input  logic [BURST_W-1:0]    avs_burstcount,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [DATA_W-1:0]     avs_writedata,
  input  logic [DATA_W/8-1:0]   avs_byteenable,
  output logic                  avs_waitrequest,
  output logic [DATA_W-1:0]     avs_readdata,
  output logic                  avs_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_clken,
  output logic                  mem_reset_req,
  input  logic [DATA_W-1:0]     mem_readdata
);

  typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_t;

  localparam logic [BURST_W-1:0] CNT_ONE  = BURST_W'(1);
  localparam logic [ADDR_W-1:0]  ADDR_ONE = ADDR_W'(1);

  state_t               state;
  logic [ADDR_W-1:0]    addr_reg;
  logic [BURST_W-1:0]   remaining;
  logic [BURST_W-1:0]   first_len;
  logic                 idle_wr, idle_rd, burst_rd, burst_wr;
  logic                 rvalid_reg;

  assign first_len = (avs_burstcount == '0) ? CNT_ONE : avs_burstcount;

  // A read burst already in progress keeps issuing until reset is sampled; writes stall under reset
  // because waitrequest is high, so the host has not handed over the beat.
  assign idle_wr  = (state == IDLE) && !reset && avs_write;
  assign idle_rd  = (state == IDLE) && !reset && avs_read && !avs_write;
  assign burst_rd = (state == RBURST);
  assign burst_wr = (state == WBURST) && !reset && avs_write;

  assign avs_waitrequest = reset || (state == RBURST);
  assign mem_writedata   = avs_writedata;
  assign mem_clken       = 1'b1;
  assign mem_reset_req   = 1'b0;

  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = addr_reg;
    mem_byteenable = '1;
    if (idle_wr) begin
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
      mem_address    = avs_address;
      mem_byteenable = avs_byteenable;
    end else if (idle_rd) begin
      mem_chipselect = 1'b1;
      mem_address    = avs_address;
    end else if (burst_rd) begin
      mem_chipselect = 1'b1;
    end else if (burst_wr) begin
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
      mem_byteenable = avs_byteenable;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_reg  <= '0;
      remaining <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if ((avs_write || avs_read) && (first_len > CNT_ONE)) begin
            addr_reg  <= avs_address + ADDR_ONE;
            remaining <= first_len - CNT_ONE;
            state     <= avs_write ? WBURST : RBURST;
          end
        end
        RBURST: begin
          addr_reg  <= addr_reg + ADDR_ONE;
          remaining <= remaining - CNT_ONE;
          if (remaining == CNT_ONE) state <= IDLE;
        end
        WBURST: begin
          if (avs_write) begin
            addr_reg  <= addr_reg + ADDR_ONE;
            remaining <= remaining - CNT_ONE;
            if (remaining == CNT_ONE) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tracks the RAM's one-cycle read latency; cleared by reset so no stale data escapes.
  always_ff @(posedge clk) begin
    if (reset) rvalid_reg <= 1'b0;
    else       rvalid_reg <= mem_chipselect && !mem_write;
  end

`ifdef EMBCPU8K_MEM_RDATA_REG_EN
  logic [DATA_W-1:0] rdata_reg;
  logic              rvalid_out_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_reg      <= '0;
      rvalid_out_reg <= 1'b0;
    end else begin
      rdata_reg      <= mem_readdata;
      rvalid_out_reg <= rvalid_reg;
    end
  end

  assign avs_readdatavalid = rvalid_out_reg && !reset;
  assign avs_readdata      = reset ? '0 : rdata_reg;
`else
  assign avs_readdatavalid = rvalid_reg && !reset;
  assign avs_readdata      = reset ? '0 : mem_readdata;
`endif

endmodule
